// File: rtl/fp_divider_seq.sv
// Iterative IEEE-754 single-precision divider: restoring division, one quotient bit per clock.
// Optional build macro ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
`timescale 1ns/1ps
module fp_divider_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [1:0]             dbg_state_o
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int ITER = MAN_W + 3;
    localparam int EW   = EXP_W + 2;
    localparam int MW   = MAN_W + 1;
    localparam int RW   = MAN_W + 2;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic signed [EW-1:0] E_MAX = EW'((2 ** EXP_W) - 1);
    localparam logic [EXP_W-1:0]     EXP_ONES = {EXP_W{1'b1}};

    // Handshake: start is honoured only in IDLE; busy covers DIV..DONE; done is high for the DONE cycle only.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_NORM = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [RW-1:0]          rem_q, rem_d;
    logic [MW-1:0]          mb_q, mb_d;
    logic [ITER-1:0]        q_q, q_d;
    logic signed [EW-1:0]   exp_q, exp_d;
    logic                   sign_q, sign_d;
    logic [W-1:0]           result_q, result_d;

    logic                   a_s, b_s;
    logic [EXP_W-1:0]       a_e, b_e;
    logic [MAN_W-1:0]       a_m, b_m;
    logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic                   sgn_in, special;
    logic [W-1:0]           special_res;
    logic signed [EW-1:0]   e_init;

    assign a_s = a[W-1];
    assign b_s = b[W-1];
    assign a_e = a[W-2:MAN_W];
    assign b_e = b[W-2:MAN_W];
    assign a_m = a[MAN_W-1:0];
    assign b_m = b[MAN_W-1:0];

    assign a_zero = (a_e == '0);
    assign b_zero = (b_e == '0);
    assign a_inf  = (a_e == EXP_ONES) && (a_m == '0);
    assign b_inf  = (b_e == EXP_ONES) && (b_m == '0);
    assign a_nan  = (a_e == EXP_ONES) && (a_m != '0);
    assign b_nan  = (b_e == EXP_ONES) && (b_m != '0);
    assign sgn_in = a_s ^ b_s;

    assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    assign e_init  = $signed({2'b00, a_e}) - $signed({2'b00, b_e}) + EW'(BIAS);

    always_comb begin
        special_res = {sgn_in, {(W-1){1'b0}}};
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            special_res = {sgn_in, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (a_inf || b_zero) begin
            special_res = {sgn_in, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    // Restoring step: remainder always stays below 2*mb, so RW = MW+1 bits suffice.
    logic              ge;
    logic [RW-1:0]     rem_sub, rem_next;
    logic [ITER-1:0]   q_next;

    assign ge       = (rem_q >= {1'b0, mb_q});
    assign rem_sub  = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    assign rem_next = {rem_sub[RW-2:0], 1'b0};
    assign q_next   = {q_q[ITER-2:0], ge};

    logic [MAN_W-1:0]      man_t, man_r;
    logic                  guard, below, sticky;
    logic signed [EW-1:0]  e_n, e_r;
    logic [W-1:0]          norm_res;

    always_comb begin
        if (q_q[ITER-1]) begin
            man_t = q_q[ITER-2:2];
            guard = q_q[1];
            below = q_q[0];
            e_n   = exp_q;
        end else begin
            man_t = q_q[ITER-3:1];
            guard = q_q[0];
            below = 1'b0;
            e_n   = exp_q - EW'(1);
        end
    end

    assign sticky = (rem_q != '0);

`ifdef ROUND_NEAREST_EN
    logic              inc, carry;
    assign inc = guard & (sticky | below | man_t[0]);
    assign {carry, man_r} = {1'b0, man_t} + {{MAN_W{1'b0}}, inc};
    assign e_r = carry ? (e_n + EW'(1)) : e_n;
`else
    logic unused_round;
    assign unused_round = ^{guard, below, sticky};
    assign man_r = man_t;
    assign e_r   = e_n;
`endif

    always_comb begin
        if (e_r >= E_MAX) begin
            norm_res = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
        end else if (e_r[EW-1] || (e_r == '0)) begin
            norm_res = {sign_q, {(W-1){1'b0}}};
        end else begin
            norm_res = {sign_q, e_r[EXP_W-1:0], man_r};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        mb_d     = mb_q;
        q_d      = q_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d = sgn_in;
                    if (special) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        rem_d   = {1'b0, 1'b1, a_m};
                        mb_d    = {1'b1, b_m};
                        q_d     = '0;
                        cnt_d   = '0;
                        exp_d   = e_init;
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                rem_d = rem_next;
                q_d   = q_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                result_d = norm_res;
                state_d  = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            mb_q     <= '0;
            q_q      <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            mb_q     <= mb_d;
            q_q      <= q_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign result      = result_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_divider_seq.sv
// Directed self-checking bench for fp_divider_seq: latency, busy window, specials, ignore-start, abort.
`timescale 1ns/1ps
module tb_fp_divider_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_divider_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .dbg_state_o (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation and watch lat+3 cycles; optionally pulse start with other operands at cycle inj_k.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] expv, input int lat, input int inj_k,
                        input logic [31:0] inj_a, input logic [31:0] inj_b);
    int          done_cyc = -1;
    int          n_done   = 0;
    int          busy_bad = 0;
    logic [31:0] res_at_done = 'x;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      start = (k == inj_k);
      if (k == inj_k) begin
        a = inj_a;
        b = inj_b;
      end
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc    = k;
          res_at_done = result;
        end
      end
      if (busy !== (k <= lat)) busy_bad++;
    end
    start = 1'b0;
    check($sformatf("%s done_cycle", tag), done_cyc, lat);
    check($sformatf("%s done_pulses", tag), n_done, 1);
    check($sformatf("%s busy_window_errors", tag), busy_bad, 0);
    check($sformatf("%s result", tag), res_at_done, expv);
    check($sformatf("%s result_held", tag), result, expv);
  endtask

  initial begin
    int n_late_done;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'h0000_0000);
    check("reset state", {30'd0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle busy", {31'd0, busy}, 32'd0);

    run_op("t1 6/2", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 28, 0, 32'h0, 32'h0);
`ifdef ROUND_NEAREST_EN
    run_op("t2 1/3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 28, 0, 32'h0, 32'h0);
`else
    run_op("t2 1/3", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 28, 0, 32'h0, 32'h0);
`endif
    run_op("t3 -8/0.5", 32'hC100_0000, 32'h3F00_0000, 32'hC180_0000, 28, 0, 32'h0, 32'h0);
    run_op("t4 1/0", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1, 0, 32'h0, 32'h0);
    run_op("t4 0/0", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1, 0, 32'h0, 32'h0);
    run_op("t4 overflow", 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 28, 0, 32'h0, 32'h0);
    run_op("nan operand", 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 1, 0, 32'h0, 32'h0);
    run_op("-1/0", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1, 0, 32'h0, 32'h0);
    run_op("1/inf", 32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 1, 0, 32'h0, 32'h0);
    run_op("inf/inf", 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1, 0, 32'h0, 32'h0);
    run_op("t5 underflow", 32'h0080_0000, 32'h7F00_0000, 32'h0000_0000, 28, 0, 32'h0, 32'h0);
    run_op("t5 start ignored", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 28, 5,
           32'h0080_0000, 32'h7F00_0000);

    // Abort: reset sampled at the end of cycle T+10 while dividing.
    @(negedge clk);
    a     = 32'h40C0_0000;
    b     = 32'h4000_0000;
    start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("t6 busy before abort", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6 abort busy", {31'd0, busy}, 32'd0);
    check("t6 abort done", {31'd0, done}, 32'd0);
    check("t6 abort result", result, 32'h0000_0000);
    n_late_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) n_late_done++;
    end
    check("t6 no late done", n_late_done, 0);
    run_op("t6 fresh t1", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 28, 0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
